seg7_scan_capture: RTL and testbench
====================================

// Module: seg7_scan_capture
// PURPOSE
//   Receive side of the 7-segment display interface: samples a multiplexed, active-low seg/an bus
//   and rebuilds the digit value shown at each anode position. Used as an on-chip display monitor
//   and self-check: BCD/display drivers loop back into it, and mismatches are flagged.
//   Pattern decode is the exact inverse of the team's BCD-to-segment table (seg[0]=a .. seg[6]=g).
// PARAMETERS
//   NUM_DIGITS     8   anode lines / captured digit slots (2..8)
//   STABLE_CYCLES  4   consecutive identical synced samples required before a capture (>=1)
// PORTS
//   clk          in   1             system clock, single domain
//   reset        in   1             synchronous, active-high reset
//   seg_in       in   7             segment lines a..g, active low (0 = lit)
//   an_in        in   NUM_DIGITS    anode lines, active low (0 = digit selected)
//   err_clr      in   1             clear sticky error flags
//   digits_out   out  4*NUM_DIGITS  captured values, slot i at [4i+3:4i]
//   digit_valid  out  NUM_DIGITS    slot i holds a decoded, non-blank digit
//   update_pulse out  1             one-cycle strobe: a slot was just written
//   update_idx   out  $clog2(NUM_DIGITS)  slot written on update_pulse
//   err_pattern  out  1             sticky: stable pattern not in decode table
//   err_anode    out  1             sticky: more than one anode low at the same time
// BEHAVIOUR
//   - seg_in/an_in pass through a 2-flop synchronizer; sync flops reset to all-ones (inactive).
//   - Reset: digits_out=0, digit_valid=0, update_pulse=0, update_idx=0, err_*=0, state IDLE.
//   - Stability counter: cleared whenever the synced {an,seg} differs from the previous synced sample.
//   - FSM: IDLE   - no anode low, or >1 anode low; counter held at 0.
//            -> SETTLE when exactly one anode is low.
//          SETTLE - count identical samples; sample change restarts count (stay SETTLE);
//            anode count != 1 -> IDLE; count reaches STABLE_CYCLES -> CAPTURE.
//          CAPTURE- single cycle: decode and write slot, update_pulse=1 -> LATCHED.
//          LATCHED- no further captures; any sample change -> SETTLE (one anode) or IDLE.
//   - Latency: inputs change before edge k and then hold -> update_pulse high in cycle k+2+STABLE_CYCLES.
//   - Decode: the ten standard 0-9 patterns -> value 0-9, digit_valid[i]=1.
//     Blank 1111111 -> digit_valid[i]=0, digits_out slot unchanged, no error.
//     Any other pattern -> err_pattern=1, digit_valid[i]=0, slot unchanged; update_pulse still fires.
//   - >1 anode low for a synced sample -> err_anode=1, state IDLE, no capture.
//   - err_clr clears both flags next cycle; a new error in the same cycle wins (flag stays 1).
//   - update_idx = index of the low anode; holds its value until the next capture.
//   - Reset mid-SETTLE/CAPTURE aborts: no pulse, no slot write, all state and outputs to reset values.
// CONFIGURATION
//   SEG7_CAPTURE_HEX_EN defined: also decode A=0001000 b=0000011 C=1000110
//     d=0100001 E=0000110 F=0001110 (bits g..a) -> values 10..15, digit_valid=1.
//   Not defined: those six patterns count as invalid -> err_pattern=1, digit_valid=0.
// TESTING
//   1. Assert reset 3 cycles with random inputs -> all outputs 0, no update_pulse.
//   2. an=11111110, seg=0010010 held 12 cycles, STABLE=4 -> exactly one pulse at k+6,
//      idx=0, digits_out[3:0]=5, digit_valid[0]=1.
//   3. Scan digits 0..7 showing 0..7, 8 cycles each -> digits_out=32'h76543210,
//      digit_valid=8'hFF, 8 pulses; repeat with seg changing after 2 cycles -> no pulse.
//   4. an=11111100 for 6 cycles -> err_anode=1, no pulse; err_clr pulse -> 0; err_clr with new
//      multi-anode sample in the same cycle -> stays 1.
//   5. Digit 3 shows 0001000 for 8 cycles -> without macro: err_pattern=1, digit_valid[3]=0,
//      pulse idx=3; with SEG7_CAPTURE_HEX_EN: digits_out[15:12]=4'hA, digit_valid[3]=1.
//   6. Reset asserted at SETTLE count 2 -> no pulse; after release, held pattern captured
//      STABLE_CYCLES+2 cycles later with correct value.

Source files
------------

// File: rtl/seg7_scan_capture.sv
// Loop-back monitor for a multiplexed active-low 7-segment bus: rebuilds the digit shown per anode.
// Optional macro SEG7_CAPTURE_HEX_EN adds decoding of the hex glyphs A,b,C,d,E,F (values 10..15).
module seg7_scan_capture #(
    parameter int unsigned NUM_DIGITS    = 8,
    parameter int unsigned STABLE_CYCLES = 4,
    localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   an_in,
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update_pulse,
    output logic [IW-1:0]           update_idx,
    output logic                    err_pattern,
    output logic                    err_anode
);

    localparam int unsigned SW   = NUM_DIGITS + 7;
    localparam int unsigned CW   = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned CNTW = $clog2(NUM_DIGITS + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, LATCHED} state_t;

    state_t          state;
    logic [SW-1:0]   sync1;
    logic [SW-1:0]   sync2;
    logic [SW-1:0]   prev;
    logic [CW-1:0]   cnt;

    logic [NUM_DIGITS-1:0] sync_an;
    logic [6:0]            sync_seg;
    logic                  changed;
    logic [CNTW-1:0]       low_cnt;
    logic [IW-1:0]         low_idx;
    logic                  one_low;
    logic                  multi_low;
    logic                  settle_done;
    logic [3:0]            dec_val;
    logic                  dec_ok;
    logic                  dec_blank;

    // Sample analysis: anode population, selected index, change detection
    always_comb begin
        sync_an  = sync2[SW-1:7];
        sync_seg = sync2[6:0];
        changed  = (sync2 != prev);
        low_cnt  = '0;
        low_idx  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!sync_an[i]) begin
                low_cnt = low_cnt + CNTW'(1);
                low_idx = IW'(i);
            end
        end
        one_low     = (low_cnt == CNTW'(1));
        multi_low   = (low_cnt > CNTW'(1));
        settle_done = (32'(cnt) + 32'd1) >= 32'(STABLE_CYCLES);
    end

    // Inverse of the BCD-to-segment table; patterns listed as g..a, active low
    always_comb begin
        dec_val   = 4'd0;
        dec_ok    = 1'b1;
        dec_blank = 1'b0;
        case (sync_seg)
            7'b1000000: dec_val = 4'd0;
            7'b1111001: dec_val = 4'd1;
            7'b0100100: dec_val = 4'd2;
            7'b0110000: dec_val = 4'd3;
            7'b0011001: dec_val = 4'd4;
            7'b0010010: dec_val = 4'd5;
            7'b0000010: dec_val = 4'd6;
            7'b1111000: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0010000: dec_val = 4'd9;
`ifdef SEG7_CAPTURE_HEX_EN
            7'b0001000: dec_val = 4'hA;
            7'b0000011: dec_val = 4'hB;
            7'b1000110: dec_val = 4'hC;
            7'b0100001: dec_val = 4'hD;
            7'b0000110: dec_val = 4'hE;
            7'b0001110: dec_val = 4'hF;
`endif
            7'b1111111: begin
                dec_ok    = 1'b0;
                dec_blank = 1'b1;
            end
            default: dec_ok = 1'b0;
        endcase
    end

    // Synchronizer, capture FSM and sticky error flags
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1        <= '1;
            sync2        <= '1;
            prev         <= '1;
            cnt          <= '0;
            state        <= IDLE;
            digits_out   <= '0;
            digit_valid  <= '0;
            update_pulse <= 1'b0;
            update_idx   <= '0;
            err_pattern  <= 1'b0;
            err_anode    <= 1'b0;
        end else begin
            sync1        <= {an_in, seg_in};
            sync2        <= sync1;
            prev         <= sync2;
            update_pulse <= 1'b0;
            err_anode    <= (err_anode & ~err_clr) | multi_low;
            err_pattern  <= err_pattern & ~err_clr;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (one_low) state <= SETTLE;
                end
                SETTLE: begin
                    if (!one_low) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (changed) begin
                        cnt <= '0;
                    end else if (settle_done) begin
                        state        <= CAPTURE;
                        cnt          <= '0;
                        update_pulse <= 1'b1;
                        update_idx   <= low_idx;
                        if (dec_ok) begin
                            digits_out[4*low_idx +: 4] <= dec_val;
                            digit_valid[low_idx]       <= 1'b1;
                        end else begin
                            digit_valid[low_idx] <= 1'b0;
                            if (!dec_blank) err_pattern <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                CAPTURE, LATCHED: begin
                    // A change seen during the capture cycle must not be lost
                    if (changed) state <= one_low ? SETTLE : IDLE;
                    else         state <= LATCHED;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed self-checking bench for seg7_scan_capture (NUM_DIGITS=8, STABLE_CYCLES=4).
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  seg_in;
    logic [7:0]  an_in;
    logic        err_clr;
    logic [31:0] digits_out;
    logic [7:0]  digit_valid;
    logic        update_pulse;
    logic [2:0]  update_idx;
    logic        err_pattern;
    logic        err_anode;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int pulses;
    int tick_no;
    int pulse_at;

    logic [6:0] pat [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    seg7_scan_capture #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .seg_in(seg_in), .an_in(an_in), .err_clr(err_clr),
        .digits_out(digits_out), .digit_valid(digit_valid), .update_pulse(update_pulse),
        .update_idx(update_idx), .err_pattern(err_pattern), .err_anode(err_anode)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        tick_no++;
        if (update_pulse) begin
            pulses++;
            pulse_at = tick_no;
        end
    endtask

    task automatic clear_counts();
        pulses   = 0;
        tick_no  = 0;
        pulse_at = -1;
    endtask

    task automatic test_reset();
        clear_counts();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            an_in   = 8'($urandom);
            seg_in  = 7'($urandom);
            err_clr = 1'($urandom);
            tick();
        end
        total_cnt++;
        if ({digits_out, digit_valid, update_idx, err_pattern, err_anode} !== 45'h0) begin
            $display("FAIL reset_outputs: got digits=%h valid=%h idx=%0d ep=%b ea=%b, expected all 0",
                     digits_out, digit_valid, update_idx, err_pattern, err_anode);
        end else pass_cnt++;
        reset = 1'b0; an_in = 8'hFF; seg_in = 7'h7F; err_clr = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total_cnt++;
        if (pulses !== 0) $display("FAIL reset_no_pulse: got %0d pulses, expected 0", pulses);
        else pass_cnt++;
        total_cnt++;
        if ({digits_out, digit_valid} !== 40'h0) $display("FAIL reset_idle: got digits=%h valid=%h, expected 0", digits_out, digit_valid);
        else pass_cnt++;
    endtask

    task automatic test_single_capture();
        clear_counts();
        an_in = 8'hFE; seg_in = 7'b0010010;
        for (int i = 0; i < 12; i++) tick();
        total_cnt++;
        if (pulses !== 1 || pulse_at !== 7)
            $display("FAIL single_latency: got %0d pulses at tick %0d, expected 1 at tick 7", pulses, pulse_at);
        else pass_cnt++;
        total_cnt++;
        if (update_idx !== 3'd0) $display("FAIL single_idx: got %0d, expected 0", update_idx);
        else pass_cnt++;
        total_cnt++;
        if (digits_out[3:0] !== 4'd5 || digit_valid[0] !== 1'b1)
            $display("FAIL single_value: got %h valid %b, expected 5 valid 1", digits_out[3:0], digit_valid[0]);
        else pass_cnt++;
    endtask

    task automatic test_scan();
        clear_counts();
        for (int d = 0; d < 8; d++) begin
            an_in = ~(8'd1 << d); seg_in = pat[d];
            for (int i = 0; i < 8; i++) tick();
        end
        total_cnt++;
        if (pulses !== 8) $display("FAIL scan_pulses: got %0d, expected 8", pulses);
        else pass_cnt++;
        total_cnt++;
        if (digits_out !== 32'h76543210 || digit_valid !== 8'hFF)
            $display("FAIL scan_digits: got %h valid %h, expected 76543210 valid ff", digits_out, digit_valid);
        else pass_cnt++;
        total_cnt++;
        if (update_idx !== 3'd7) $display("FAIL scan_idx: got %0d, expected 7", update_idx);
        else pass_cnt++;
    endtask

    task automatic test_unstable();
        clear_counts();
        for (int d = 0; d < 8; d++) begin
            an_in = ~(8'd1 << d);
            for (int i = 0; i < 8; i++) begin
                if (i % 2 == 0) seg_in = (i % 4 == 0) ? pat[8] : pat[9];
                tick();
            end
        end
        an_in = 8'hFF; seg_in = 7'h7F;
        for (int i = 0; i < 6; i++) tick();
        total_cnt++;
        if (pulses !== 0) $display("FAIL unstable_pulses: got %0d, expected 0", pulses);
        else pass_cnt++;
        total_cnt++;
        if (digits_out !== 32'h76543210) $display("FAIL unstable_digits: got %h, expected 76543210", digits_out);
        else pass_cnt++;
    endtask

    task automatic test_anode_error();
        clear_counts();
        an_in = 8'hFC; seg_in = pat[0];
        for (int i = 0; i < 6; i++) tick();
        total_cnt++;
        if (err_anode !== 1'b1 || pulses !== 0)
            $display("FAIL anode_err_set: got err=%b pulses=%0d, expected err=1 pulses=0", err_anode, pulses);
        else pass_cnt++;
        an_in = 8'hFF; seg_in = 7'h7F;
        for (int i = 0; i < 4; i++) tick();
        total_cnt++;
        if (err_anode !== 1'b1) $display("FAIL anode_err_sticky: got %b, expected 1", err_anode);
        else pass_cnt++;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        total_cnt++;
        if (err_anode !== 1'b0) $display("FAIL anode_err_clr: got %b, expected 0", err_anode);
        else pass_cnt++;
        an_in = 8'hF5;
        for (int i = 0; i < 4; i++) tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        total_cnt++;
        if (err_anode !== 1'b1) $display("FAIL anode_err_clr_race: got %b, expected 1", err_anode);
        else pass_cnt++;
        an_in = 8'hFF;
        for (int i = 0; i < 4; i++) tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        total_cnt++;
        if (err_anode !== 1'b0 || pulses !== 0)
            $display("FAIL anode_err_final: got err=%b pulses=%0d, expected 0 and 0", err_anode, pulses);
        else pass_cnt++;
    endtask

    task automatic test_pattern();
        clear_counts();
        an_in = 8'hEF; seg_in = 7'h7F;
        for (int i = 0; i < 8; i++) tick();
        total_cnt++;
        if (pulses !== 1 || digit_valid[4] !== 1'b0 || digits_out[19:16] !== 4'd4 || err_pattern !== 1'b0)
            $display("FAIL blank_digit: got pulses=%0d valid=%b val=%h ep=%b, expected 1 0 4 0",
                     pulses, digit_valid[4], digits_out[19:16], err_pattern);
        else pass_cnt++;
        clear_counts();
        an_in = 8'hF7; seg_in = 7'b0001000;
        for (int i = 0; i < 8; i++) tick();
        total_cnt++;
        if (pulses !== 1 || pulse_at !== 7 || update_idx !== 3'd3)
            $display("FAIL hex_pulse: got %0d pulses at %0d idx %0d, expected 1 at 7 idx 3", pulses, pulse_at, update_idx);
        else pass_cnt++;
`ifdef SEG7_CAPTURE_HEX_EN
        total_cnt++;
        if (digits_out[15:12] !== 4'hA || digit_valid[3] !== 1'b1 || err_pattern !== 1'b0)
            $display("FAIL hex_decode: got val=%h valid=%b ep=%b, expected a 1 0", digits_out[15:12], digit_valid[3], err_pattern);
        else pass_cnt++;
`else
        total_cnt++;
        if (digits_out[15:12] !== 4'd3 || digit_valid[3] !== 1'b0 || err_pattern !== 1'b1)
            $display("FAIL hex_invalid: got val=%h valid=%b ep=%b, expected 3 0 1", digits_out[15:12], digit_valid[3], err_pattern);
        else pass_cnt++;
`endif
        an_in = 8'hFF; seg_in = 7'h7F;
        for (int i = 0; i < 3; i++) tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        total_cnt++;
        if (err_pattern !== 1'b0) $display("FAIL pattern_err_clr: got %b, expected 0", err_pattern);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        clear_counts();
        an_in = 8'hFB; seg_in = pat[9];
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        total_cnt++;
        if (pulses !== 0 || digits_out !== 32'h0 || digit_valid !== 8'h0)
            $display("FAIL abort_reset: got pulses=%0d digits=%h valid=%h, expected 0", pulses, digits_out, digit_valid);
        else pass_cnt++;
        clear_counts();
        for (int i = 0; i < 10; i++) tick();
        total_cnt++;
        if (pulses !== 1 || pulse_at !== 7)
            $display("FAIL abort_recapture: got %0d pulses at tick %0d, expected 1 at tick 7", pulses, pulse_at);
        else pass_cnt++;
        total_cnt++;
        if (digits_out !== 32'h00000900 || digit_valid !== 8'h04 || update_idx !== 3'd2)
            $display("FAIL abort_value: got digits=%h valid=%h idx=%0d, expected 00000900 04 2", digits_out, digit_valid, update_idx);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; an_in = 8'hFF; seg_in = 7'h7F; err_clr = 1'b0;
        test_reset();
        test_single_capture();
        test_scan();
        test_unstable();
        test_anode_error();
        test_pattern();
        test_reset_abort();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
